// File: rtl/fft_peak_pkg.sv
// Shared types and sizing helpers for the FFT peak-bin extractor.
package fft_peak_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        REPORT = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam int MAG_W = 32;

    function automatic int bin_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Three-stage |X|^2 pipeline: S1 capture, S2 square, S3 sum; control bits ride alongside.
module fft_mag_sq
    import fft_peak_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [15:0]      i_re,
    input  logic [15:0]      i_im,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic [BIN_W-1:0] i_bin,
    output logic [MAG_W-1:0] o_mag,
    output logic             o_valid,
    output logic             o_last,
    output logic [BIN_W-1:0] o_bin
);

    logic [15:0]      r1_re, r1_im;
    logic [BIN_W-1:0] r1_bin, r2_bin, r3_bin;
    logic             r1_last, r2_last, r3_last;
    logic             r1_valid, r2_valid, r3_valid;
    logic [31:0]      r2_re_sq, r2_im_sq;
    logic [MAG_W-1:0] r3_mag;
    logic [31:0]      w_re_ext, w_im_ext;

    // Low 32 bits of a product of sign-extended operands equal the signed square.
    assign w_re_ext = {{16{r1_re[15]}}, r1_re};
    assign w_im_ext = {{16{r1_im[15]}}, r1_im};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
        end else begin
            r1_valid <= i_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits qualify them, so
    // leaving them unreset saves reset fan-out without changing behaviour.
    always_ff @(posedge clk_in) begin
        r1_re    <= i_re;
        r1_im    <= i_im;
        r1_bin   <= i_bin;
        r1_last  <= i_last;
        r2_re_sq <= w_re_ext * w_re_ext;
        r2_im_sq <= w_im_ext * w_im_ext;
        r2_bin   <= r1_bin;
        r2_last  <= r1_last;
        r3_mag   <= r2_re_sq + r2_im_sq;
        r3_bin   <= r2_bin;
        r3_last  <= r2_last;
    end

    assign o_mag   = r3_mag;
    assign o_valid = r3_valid;
    assign o_last  = r3_last & r3_valid;
    assign o_bin   = r3_bin;

endmodule

// File: rtl/fft_peak_bin_extractor.sv
// Per-frame dominant FFT bin finder. Optional `PEAK_SILENCE_GATE_EN reports
// bin 0 with silent_out when the winning |X|^2 is below THRESHOLD.
module fft_peak_bin_extractor
    import fft_peak_pkg::*;
#(
    parameter int          N_FFT     = 1024,
    parameter int          MIN_BIN   = 2,
    parameter int          MAX_BIN   = 511,
    parameter logic [31:0] THRESHOLD = 32'd4096
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] fft_tdata_in,
    input  logic        fft_tvalid_in,
    input  logic        fft_tlast_in,
    output logic [31:0] peak_bin_out,
    output logic [31:0] peak_mag_out,
    output logic        peak_valid_out,
    output logic        peak_last_out,
    output logic        frame_err_out,
    output logic        silent_out
);

    localparam int               BIN_W = bin_w(N_FFT);
    localparam logic [BIN_W-1:0] MIN_B  = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] MAX_B  = BIN_W'(MAX_BIN);
    localparam logic [BIN_W-1:0] LAST_B = BIN_W'(N_FFT - 1);
`ifdef PEAK_SILENCE_GATE_EN
    localparam bit SILENCE_GATE = 1'b1;
`else
    localparam bit SILENCE_GATE = 1'b0;
`endif

    state_t           r_state, w_state_next;
    logic [BIN_W-1:0] r_bin_cnt, r_best_bin, r_peak_bin;
    logic [MAG_W-1:0] r_best_mag, r_peak_mag;
    logic             r_have, r_silent;
    logic [MAG_W-1:0] w_mag, w_cand_mag;
    logic [BIN_W-1:0] w_s3_bin, w_cand_bin;
    logic             w_s3_valid, w_s3_last, w_in_win, w_take, w_at_end;
    logic             w_close_ok, w_close_err, w_silent, w_report, w_err;

    // Counter is exactly log2(N_FFT) wide, so bin N_FFT-1 wraps to 0 by itself.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            r_bin_cnt <= '0;
        else if (fft_tvalid_in)
            r_bin_cnt <= fft_tlast_in ? '0 : r_bin_cnt + 1'b1;
    end

    fft_mag_sq #(.BIN_W(BIN_W)) u_mag_sq (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_re     (fft_tdata_in[15:0]),
        .i_im     (fft_tdata_in[31:16]),
        .i_valid  (fft_tvalid_in),
        .i_last   (fft_tlast_in),
        .i_bin    (r_bin_cnt),
        .o_mag    (w_mag),
        .o_valid  (w_s3_valid),
        .o_last   (w_s3_last),
        .o_bin    (w_s3_bin)
    );

    assign w_in_win    = (w_s3_bin >= MIN_B) && (w_s3_bin <= MAX_B);
    assign w_take      = w_s3_valid && w_in_win && (!r_have || (w_mag > r_best_mag));
    assign w_cand_mag  = w_take ? w_mag : r_best_mag;
    assign w_cand_bin  = w_take ? w_s3_bin : r_best_bin;
    assign w_at_end    = (w_s3_bin == LAST_B);
    assign w_close_ok  = w_s3_valid && w_s3_last && w_at_end;
    assign w_close_err = w_s3_valid && (w_s3_last != w_at_end);
    assign w_silent    = SILENCE_GATE && (w_cand_mag < THRESHOLD);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_best_mag <= '0;
            r_best_bin <= MIN_B;
            r_have     <= 1'b0;
        end else if (w_close_ok || w_close_err) begin
            r_best_mag <= '0;
            r_best_bin <= MIN_B;
            r_have     <= 1'b0;
        end else if (w_take) begin
            r_best_mag <= w_mag;
            r_best_bin <= w_s3_bin;
            r_have     <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_peak_bin <= '0;
            r_peak_mag <= '0;
            r_silent   <= 1'b0;
            r_state    <= ACCUM;
        end else begin
            r_state <= w_state_next;
            if (w_close_ok) begin
                r_peak_bin <= w_silent ? '0 : w_cand_bin;
                r_peak_mag <= w_cand_mag;
                r_silent   <= w_silent;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = ACCUM;
        w_report     = 1'b0;
        w_err        = 1'b0;
        if (w_close_ok)
            w_state_next = REPORT;
        else if (w_close_err)
            w_state_next = ERR;
        case (r_state)
            REPORT:  w_report = 1'b1;
            ERR:     w_err    = 1'b1;
            default: ;
        endcase
    end

    assign peak_bin_out   = {{(32 - BIN_W){1'b0}}, r_peak_bin};
    assign peak_mag_out   = r_peak_mag;
    assign peak_valid_out = w_report;
    assign peak_last_out  = w_report;
    assign frame_err_out  = w_err;
    assign silent_out     = w_report & r_silent;

endmodule

// File: tb/tb_fft_peak_bin_extractor.sv
// Scoreboard bench: frame-level reference model pushes expected pulses; a monitor pops and compares.
module tb_fft_peak_bin_extractor;

    localparam int N    = 16;
    localparam int MINB = 2;
    localparam int MAXB = 7;
`ifdef PEAK_SILENCE_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] fft_tdata_in;
    logic        fft_tvalid_in;
    logic        fft_tlast_in;
    logic [31:0] peak_bin_out;
    logic [31:0] peak_mag_out;
    logic        peak_valid_out;
    logic        peak_last_out;
    logic        frame_err_out;
    logic        silent_out;

    fft_peak_bin_extractor #(
        .N_FFT     (N),
        .MIN_BIN   (MINB),
        .MAX_BIN   (MAXB),
        .THRESHOLD (32'd4096)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .fft_tdata_in   (fft_tdata_in),
        .fft_tvalid_in  (fft_tvalid_in),
        .fft_tlast_in   (fft_tlast_in),
        .peak_bin_out   (peak_bin_out),
        .peak_mag_out   (peak_mag_out),
        .peak_valid_out (peak_valid_out),
        .peak_last_out  (peak_last_out),
        .frame_err_out  (frame_err_out),
        .silent_out     (silent_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct {
        bit          err;
        logic [31:0] bin;
        logic [31:0] mag;
        bit          silent;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          fr_re[N];
    int          fr_im[N];
    logic [31:0] last_bin = '0;
    logic [31:0] last_mag = '0;
    bit          rand_bubbles = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (peak_valid_out || frame_err_out) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b expected none at cycle %0d",
                         peak_valid_out, frame_err_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_valid", 32'(peak_valid_out), 32'(!e.err));
                check("pulse_err",   32'(frame_err_out),  32'(e.err));
                check("last_eq_valid", 32'(peak_last_out), 32'(!e.err));
                check("pulse_cycle", cyc, e.cyc);
                check("peak_bin",    peak_bin_out, e.bin);
                check("peak_mag",    peak_mag_out, e.mag);
                check("silent",      32'(silent_out), 32'(e.silent));
            end
        end
    end

    task automatic drive(input int re, input int im, input bit v, input bit l);
        logic [31:0] tre;
        logic [31:0] tim;
        tre = re;
        tim = im;
        @(posedge clk_in);
        #1;
        fft_tdata_in  = {tim[15:0], tre[15:0]};
        fft_tvalid_in = v;
        fft_tlast_in  = l;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    function automatic longint mag_of(input int b);
        return longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
    endfunction

    // Sends bins 0..len-1; a frame closes on tlast or after bin N-1.
    task automatic send_frame(input int len, input bit with_last);
        exp_t   e;
        longint best_m;
        int     best_b;
        for (int i = 0; i < len; i++) begin
            if (rand_bubbles) idle($urandom_range(0, 2));
            drive(fr_re[i], fr_im[i], 1'b1, with_last && (i == len - 1));
        end
        e.cyc = cyc + 4;
        if (with_last && len == N) begin
            best_b = -1;
            best_m = 0;
            for (int b = MINB; b <= MAXB; b++)
                if (best_b < 0 || mag_of(b) > best_m) begin
                    best_b = b;
                    best_m = mag_of(b);
                end
            e.err    = 1'b0;
            e.mag    = 32'(best_m);
            e.silent = GATE && (best_m < 4096);
            e.bin    = e.silent ? 32'd0 : 32'(best_b);
            last_bin = e.bin;
            last_mag = e.mag;
        end else begin
            e.err    = 1'b1;
            e.silent = 1'b0;
            e.bin    = last_bin;
            e.mag    = last_mag;
        end
        q.push_back(e);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        fft_tdata_in  = '0;
        fft_tvalid_in = 1'b0;
        fft_tlast_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_bin",   peak_bin_out, 32'd0);
        check("rst_mag",   peak_mag_out, 32'd0);
        check("rst_valid", 32'(peak_valid_out), 32'd0);
        check("rst_last",  32'(peak_last_out), 32'd0);
        check("rst_err",   32'(frame_err_out), 32'd0);
        check("rst_silent", 32'(silent_out), 32'd0);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        idle(2);

        // Single tone at bin 5.
        clear_frame(); fr_re[5] = 100;
        send_frame(N, 1'b1); idle(6);

        // Tie at bins 3 and 6 (mag 500 each): lower bin wins.
        clear_frame(); fr_re[3] = 20; fr_im[3] = 10; fr_re[6] = 10; fr_im[6] = 20;
        send_frame(N, 1'b1); idle(6);

        // Out-of-window peaks at bins 1 and 9 are ignored.
        clear_frame(); fr_re[1] = 1000; fr_re[9] = -1000; fr_re[4] = 5;
        send_frame(N, 1'b1); idle(6);

        // Early tlast at bin 10 with a large peak, then a clean weak frame back to back.
        clear_frame(); fr_re[5] = 3000;
        send_frame(11, 1'b1);
        clear_frame(); fr_im[6] = 50;
        send_frame(N, 1'b1); idle(6);

        // Missing tlast, then a clean frame with extreme negative input at MAX bin.
        clear_frame(); fr_re[3] = 7000;
        send_frame(N, 1'b0);
        clear_frame(); fr_re[MAXB] = -32768; fr_im[MAXB] = -32768; fr_re[MINB] = 1;
        send_frame(N, 1'b1); idle(6);

        // Back-to-back frames, then reset in the middle of a third.
        clear_frame(); fr_re[3] = 400;
        send_frame(N, 1'b1);
        clear_frame(); fr_re[6] = 400;
        send_frame(N, 1'b1);
        for (int i = 0; i < 8; i++) drive(1000, 1000, 1'b1, 1'b0);
        @(posedge clk_in);
        #1;
        rst_n_in      = 1'b0;
        fft_tvalid_in = 1'b0;
        @(negedge clk_in);
        check("midrst_bin", peak_bin_out, 32'd0);
        check("midrst_mag", peak_mag_out, 32'd0);
        check("midrst_pending", q.size(), 0);
        idle(2);
        #1 rst_n_in = 1'b1;
        last_bin = '0;
        last_mag = '0;
        idle(20);
        clear_frame(); fr_re[MAXB] = 300;
        send_frame(N, 1'b1); idle(6);

        // Quiet frame: every |X|^2 below 4096.
        clear_frame(); fr_re[5] = 10; fr_im[2] = 3;
        send_frame(N, 1'b1); idle(6);

        // Randomized frames with bubbles and occasional framing errors.
        rand_bubbles = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int kind;
            bit quiet;
            kind  = $urandom_range(0, 5);
            quiet = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                fr_re[i] = quiet ? $urandom_range(0, 80) - 40 : $urandom_range(0, 65535) - 32768;
                fr_im[i] = quiet ? $urandom_range(0, 80) - 40 : $urandom_range(0, 65535) - 32768;
            end
            if (kind == 0)      send_frame($urandom_range(1, N - 1), 1'b1);
            else if (kind == 1) send_frame(N, 1'b0);
            else                send_frame(N, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(10);
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
